mem_access_unit: RTL and testbench

- Data-memory access stage between EX and the load-extension formatter in core_pipeline.
- Accepts one load/store per transaction from EX and drives a req/ack data-memory bus.
- Stalls the pipeline until the bus acknowledges.
- Loads: delivers the byte-lane-aligned, right-justified raw word plus funct3 to the downstream sign/zero-extension block. Stores: generates byte strobes and lane-replicated write data. Misaligned, unsupported and timed-out accesses are reported as faults.

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access stage: issues one load/store on a req/ack bus,
// stalls until ack, and reports misaligned, unsupported and timed-out accesses.
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [2:0]  ld_funct3,
    output logic [31:0] ld_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       off, off_n;
    logic [2:0]       f3, f3_n;

    logic        req_n, we_n, ldv_n, fault_n;
    logic [31:0] addr_n, wdata_n, ldd_n;
    logic [3:0]  wstrb_n;
    logic [2:0]  ldf3_n;
    logic [1:0]  cause_n;

    logic op, unsup, mis, to_hit;

    assign op = ex_valid & (ex_load | ex_store);

    // Loads allow 000/001/010/100/101; stores only 000/001/010.
    assign unsup = ex_load
        ? ((ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) | (ex_funct3 == 3'b111))
        : (ex_funct3[2] | (ex_funct3[1:0] == 2'b11));

    assign mis = ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
               | ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));

    assign to_hit = (cnt == CNT_MAX);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        off_n   = off;
        f3_n    = f3;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wstrb_n = mem_wstrb;
        wdata_n = mem_wdata;
        ldv_n   = 1'b0;
        ldf3_n  = ld_funct3;
        ldd_n   = ld_data;
        fault_n = 1'b0;
        cause_n = 2'b00;
        stall   = 1'b0;
        unique case (state)
            IDLE: begin
                if (op) begin
                    if (unsup) begin
                        fault_n = 1'b1;
                        cause_n = 2'b10;
                    end else if (mis) begin
                        fault_n = 1'b1;
                        cause_n = 2'b01;
                    end else begin
                        stall   = 1'b1;
                        state_n = BUSY;
                        cnt_n   = '0;
                        req_n   = 1'b1;
                        we_n    = ex_store;
                        addr_n  = {ex_addr[31:2], 2'b00};
                        off_n   = ex_addr[1:0];
                        f3_n    = ex_funct3;
                        wstrb_n = 4'b0000;
                        wdata_n = 32'h0;
                        if (ex_store) begin
                            unique case (ex_funct3[1:0])
                                2'b00: begin
                                    wstrb_n = 4'b0001 << ex_addr[1:0];
                                    wdata_n = {4{ex_wdata[7:0]}};
                                end
                                2'b01: begin
                                    wstrb_n = 4'b0011 << ex_addr[1:0];
                                    wdata_n = {2{ex_wdata[15:0]}};
                                end
                                default: begin
                                    wstrb_n = 4'b1111;
                                    wdata_n = ex_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            BUSY: begin
                // The final timeout cycle releases the pipeline along with the bus.
                stall = ~mem_ack & ~to_hit;
                if (mem_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                    if (!mem_we) begin
                        ldv_n  = 1'b1;
                        ldd_n  = mem_rdata >> {off, 3'b000};
                        ldf3_n = f3;
                    end
                end else if (to_hit) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                    fault_n = 1'b1;
                    cause_n = 2'b11;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            off         <= 2'b00;
            f3          <= 3'b000;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wstrb   <= 4'b0000;
            mem_wdata   <= 32'h0;
            ld_valid    <= 1'b0;
            ld_funct3   <= 3'b000;
            ld_data     <= 32'h0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            off         <= off_n;
            f3          <= f3_n;
            mem_req     <= req_n;
            mem_we      <= we_n;
            mem_addr    <= addr_n;
            mem_wstrb   <= wstrb_n;
            mem_wdata   <= wdata_n;
            ld_valid    <= ldv_n;
            ld_funct3   <= ldf3_n;
            ld_data     <= ldd_n;
            fault       <= fault_n;
            fault_cause <= cause_n;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with TIMEOUT=4,
// plus hand sequences for wait states, timeout, reset and back-to-back.
module tb_mem_access_unit;

    logic        clk, rst;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_funct3(ld_funct3), .ld_data(ld_data),
        .fault(fault), .fault_cause(fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  cause;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic [31:0] ldata;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd);
        ex_valid  = 1'b1;
        ex_load   = ld;
        ex_store  = st;
        ex_funct3 = f;
        ex_addr   = a;
        ex_wdata  = wd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.ld, v.st, v.f3, v.addr, v.wdata);
        mem_ack = 1'b0;
        #1 chk($sformatf("v%0d stall_issue", idx), 32'(stall), 32'(v.cause == 2'b00));
        @(negedge clk);
        ex_valid = 1'b0;
        if (v.cause == 2'b00) begin
            chk($sformatf("v%0d req", idx), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d addr", idx), mem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d we", idx), 32'(mem_we), 32'(v.we));
            chk($sformatf("v%0d wstrb", idx), 32'(mem_wstrb), 32'(v.wstrb));
            if (v.st) chk($sformatf("v%0d wdata", idx), mem_wdata, v.mwdata);
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            #1 chk($sformatf("v%0d stall_ack", idx), 32'(stall), 32'd0);
            @(negedge clk);
            mem_ack = 1'b0;
            chk($sformatf("v%0d ld_valid", idx), 32'(ld_valid), 32'(v.ld));
            if (v.ld) begin
                chk($sformatf("v%0d ld_data", idx), ld_data, v.ldata);
                chk($sformatf("v%0d ld_f3", idx), 32'(ld_funct3), 32'(v.f3));
            end
            chk($sformatf("v%0d nofault", idx), 32'(fault), 32'd0);
            chk($sformatf("v%0d req_drop", idx), 32'(mem_req), 32'd0);
        end else begin
            chk($sformatf("v%0d fault", idx), 32'(fault), 32'd1);
            chk($sformatf("v%0d cause", idx), 32'(fault_cause), 32'(v.cause));
            chk($sformatf("v%0d noreq", idx), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d ldv", idx), 32'(ld_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d fault_pulse", idx), 32'(fault), 32'd0);
        end
    endtask

    initial begin
        int req_cycles;
        int stall_cycles;
        int fault_cnt;
        int fault_at;
        logic [1:0] fcause;

        tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 2'b00, 1'b0, 4'b0000, 32'h0, 32'h00000080};
        tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 2'b00, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 3'b000, 32'h0011, 32'h000000A5, 32'h0, 2'b00, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 3'b010, 32'h0000, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h0006, 32'h0, 32'h11223344, 2'b00, 1'b0, 4'b0000, 32'h0, 32'h00001122};
        tbl[5]  = '{1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 2'b01, 1'b0, 4'b0000, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 3'b011, 32'h0000, 32'h0, 32'h0, 2'b10, 1'b0, 4'b0000, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 3'b100, 32'h0000, 32'h0, 32'h0, 2'b10, 1'b0, 4'b0000, 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h0005, 32'h0, 32'h0, 2'b01, 1'b0, 4'b0000, 32'h0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'b010, 32'h0040, 32'h0, 32'hCAFEF00D, 2'b00, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D};
        tbl[10] = '{1'b1, 1'b0, 3'b100, 32'h0042, 32'h0, 32'h12345678, 2'b00, 1'b0, 4'b0000, 32'h0, 32'h00001234};

        rst = 1'b1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst ld_valid", 32'(ld_valid), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // LB 0x1003 with ack in the third BUSY cycle
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0);
        stall_cycles = 0;
        #1 stall_cycles += int'(stall);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            if (i == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h80AABBCC;
            end
            chk("lb_wait mem_addr", mem_addr, 32'h1000);
            #1 stall_cycles += int'(stall);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lb_wait stall_cycles", 32'(stall_cycles), 32'd3);
        chk("lb_wait ld_valid", 32'(ld_valid), 32'd1);
        chk("lb_wait ld_data", ld_data, 32'h00000080);
        chk("lb_wait ld_f3", 32'(ld_funct3), 32'd0);

        // Timeout: no ack at all
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0100, 32'h0);
        req_cycles = 0; fault_cnt = 0; fault_at = -1; fcause = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            if (mem_req) begin
                req_cycles++;
                chk($sformatf("to stall_c%0d", req_cycles), 32'(stall),
                    32'(req_cycles < 4));
            end
            if (fault) begin
                fault_cnt++;
                fault_at = i;
                fcause = fault_cause;
            end
        end
        chk("to req_cycles", 32'(req_cycles), 32'd4);
        chk("to fault_cnt", 32'(fault_cnt), 32'd1);
        chk("to fault_at", 32'(fault_at), 32'd4);
        chk("to cause", 32'(fcause), 32'd3);

        // Ack in the final timeout cycle wins
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h55AA33CC;
            end
        end
        #1 chk("to_ack stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("to_ack ld_valid", 32'(ld_valid), 32'd1);
        chk("to_ack ld_data", ld_data, 32'h55AA33CC);
        chk("to_ack fault", 32'(fault), 32'd0);
        @(negedge clk);
        chk("to_ack fault_late", 32'(fault), 32'd0);

        // Reset in the middle of BUSY
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h0100, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstmid req_before", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rstmid req", 32'(mem_req), 32'd0);
        chk("rstmid stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rstmid ld_valid", 32'(ld_valid), 32'd0);
        chk("rstmid fault", 32'(fault), 32'd0);

        // Back-to-back SW 0x0 then LHU 0x6
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'h0000, 32'h01020304);
        #1 chk("b2b sw stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("b2b sw req", 32'(mem_req), 32'd1);
        chk("b2b sw we", 32'(mem_we), 32'd1);
        chk("b2b sw wstrb", 32'(mem_wstrb), 32'hF);
        chk("b2b sw wdata", mem_wdata, 32'h01020304);
        mem_ack = 1'b1;
        #1 chk("b2b sw stall_ack", 32'(stall), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b gap req", 32'(mem_req), 32'd0);
        chk("b2b sw no_ldv", 32'(ld_valid), 32'd0);
        drive(1'b1, 1'b0, 3'b101, 32'h0006, 32'h0);
        #1 chk("b2b lhu stall", 32'(stall), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("b2b lhu req", 32'(mem_req), 32'd1);
        chk("b2b lhu addr", mem_addr, 32'h4);
        chk("b2b lhu we", 32'(mem_we), 32'd0);
        chk("b2b lhu wstrb", 32'(mem_wstrb), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hBEEF1234;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b lhu ld_valid", 32'(ld_valid), 32'd1);
        chk("b2b lhu ld_data", ld_data, 32'h0000BEEF);
        chk("b2b lhu ld_f3", 32'(ld_funct3), 32'd5);
        @(negedge clk);
        chk("b2b ldv_pulse", 32'(ld_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
